// File: rtl/cd_pkg.sv
// -----------------------------------------------------------------------------
// cd_pkg -- shared definitions for the coherence-domain request initiator.
//
// Contents:
//   - flit field offsets (64-bit flit: llc id, src id, tag, payload)
//   - FSM state encoding of cd_req_initiator
//   - watchdog limit used when CD_INIT_TIMEOUT_EN is defined
//   - make_req_flit(): builds a request flit from a source id and tag
// -----------------------------------------------------------------------------
package cd_pkg;

  localparam int FLIT_W = 64;

  localparam int LLC_HI = 63;
  localparam int LLC_LO = 62;
  localparam int SRC_HI = 61;
  localparam int SRC_LO = 58;
  localparam int TAG_HI = 57;
  localparam int TAG_LO = 50;
  localparam int PAY_HI = 49;
  localparam int PAY_LO = 0;

  localparam logic [15:0] WD_LIMIT = 16'd1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The llc id is the low two bits of the tag; the payload carries the tag too.
  function automatic logic [FLIT_W-1:0] make_req_flit(input logic [3:0] src,
                                                      input logic [7:0] tag);
    logic [FLIT_W-1:0] f;
    f                = '0;
    f[LLC_HI:LLC_LO] = tag[1:0];
    f[SRC_HI:SRC_LO] = src;
    f[TAG_HI:TAG_LO] = tag;
    f[PAY_HI:PAY_LO] = {42'b0, tag};
    return f;
  endfunction

endpackage

// File: rtl/cd_init_slot_tracker.sv
// -----------------------------------------------------------------------------
// cd_init_slot_tracker -- per-slot pending flag and reply-flit counter.
//
// A slot becomes pending with count 0 when a request is issued into it. Each
// reply flit for a pending slot bumps its count; the flit that brings the count
// to BURST retires the slot. The caller only issues into non-pending slots and
// only forwards replies for pending slots, so an issue and a retire in the same
// cycle always touch different slots.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   clear_i           drop every slot (watchdog expiry)
//   issue_i           request transferred this cycle into issue_slot_i
//   reply_i           accepted reply flit for reply_slot_i
//   pending_o         pending flag per slot
//   outstanding_o     number of pending slots
// -----------------------------------------------------------------------------
module cd_init_slot_tracker #(
  parameter int MAX_OUT = 4,
  parameter int BURST   = 2,
  parameter int SLOT_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               issue_i,
  input  logic [SLOT_W-1:0]  issue_slot_i,
  input  logic               reply_i,
  input  logic [SLOT_W-1:0]  reply_slot_i,
  output logic [MAX_OUT-1:0] pending_o,
  output logic [4:0]         outstanding_o
);

  localparam int CNT_W = $clog2(BURST + 1);

  logic [MAX_OUT-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q [MAX_OUT];
  logic [CNT_W-1:0]   cnt_d [MAX_OUT];

  always_comb begin
    pending_d = pending_q;
    for (int s = 0; s < MAX_OUT; s++) cnt_d[s] = cnt_q[s];

    if (reply_i) begin
      if (cnt_q[reply_slot_i] == CNT_W'(BURST - 1)) begin
        pending_d[reply_slot_i] = 1'b0;
        cnt_d[reply_slot_i]     = '0;
      end else begin
        cnt_d[reply_slot_i] = cnt_q[reply_slot_i] + 1'b1;
      end
    end

    if (issue_i) begin
      pending_d[issue_slot_i] = 1'b1;
      cnt_d[issue_slot_i]     = '0;
    end

    if (clear_i) begin
      pending_d = '0;
      for (int s = 0; s < MAX_OUT; s++) cnt_d[s] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      for (int s = 0; s < MAX_OUT; s++) cnt_q[s] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int s = 0; s < MAX_OUT; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int s = 0; s < MAX_OUT; s++) outstanding_o = outstanding_o + 5'(pending_q[s]);
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/cd_req_initiator.sv
// -----------------------------------------------------------------------------
// cd_req_initiator -- issues a run of tagged requests and tracks their replies.
//
// A start pulse latches num_req and issues requests with tags 0..num_req-1 in
// order. A request only goes out when the slot (tag mod MAX_OUT) for its tag
// has no reply burst pending. Each request expects BURST reply flits; replies
// may interleave between slots. Malformed replies set the sticky err flag and
// are dropped.
//
// Handshake (both channels): a flit moves on a cycle where valid and ready are
// both high; valid never depends on ready, and the request flit is held stable
// while so is high and ro is low.
//
// Optional build macro: CD_INIT_TIMEOUT_EN adds a 16-bit reply watchdog that
// abandons the run (clears all slots, sets timeout, goes to DONE) after
// WD_LIMIT cycles without a reply flit while requests are outstanding.
// Without it, timeout is tied low.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   start, num_req         run start pulse, number of requests in the run
//   so, ro, do_o           request valid / ready / flit ('do' is reserved)
//   si_r, ri_r, di_r       reply valid / ready / flit
//   busy, done             in ISSUE or DRAIN / in DONE
//   outstanding            number of pending slots
//   err, timeout           sticky protocol error / sticky watchdog expiry
//   dbg_state_o            current FSM state
// -----------------------------------------------------------------------------
module cd_req_initiator
  import cd_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SRC_ID  = 0,
  parameter int MAX_OUT = 4,
  parameter int BURST   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        num_req,
  output logic              so,
  input  logic              ro,
  output logic [DATA_W-1:0] do_o,
  input  logic              si_r,
  output logic              ri_r,
  input  logic [DATA_W-1:0] di_r,
  output logic              busy,
  output logic              done,
  output logic [4:0]        outstanding,
  output logic              err,
  output logic              timeout,
  output logic [1:0]        dbg_state_o
);

  localparam int          SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [3:0]  SRC    = SRC_ID[3:0];

  state_e            state_q, state_d;
  logic [7:0]        next_tag_q, next_tag_d;
  logic [7:0]        num_req_q, num_req_d;
  logic              err_q;
  logic [MAX_OUT-1:0] pending;
  logic [4:0]        outstanding_w;
  logic              so_w;
  logic              req_fire;
  logic              wd_expire;
  logic [DATA_W-1:0] req_flit;

  // Reply decode
  logic              reply_fire;
  logic [7:0]        reply_tag;
  logic [3:0]        reply_src;
  logic [SLOT_W-1:0] reply_slot;
  logic              reply_bad;
  logic              reply_ok;
  logic              unused_reply_bits;

  // Ready follows reset directly: replies are accepted in every state.
  assign ri_r       = reset;
  assign reply_fire = si_r && ri_r;
  assign reply_tag  = di_r[TAG_HI:TAG_LO];
  assign reply_src  = di_r[SRC_HI:SRC_LO];
  assign reply_slot = reply_tag[SLOT_W-1:0];
  // Tags at or above next_tag_q were never issued in this run.
  assign reply_bad  = (reply_src != SRC) || (reply_tag >= next_tag_q) || !pending[reply_slot];
  assign reply_ok   = reply_fire && !reply_bad;
  // llc id and payload of replies carry nothing the initiator needs.
  assign unused_reply_bits = ^di_r;

  always_comb begin
    req_flit         = '0;
    req_flit[63:0]   = make_req_flit(SRC, next_tag_q);
  end

  assign req_fire = so_w && ro;

  // ---------------------------------------------------------------------------
  // FSM: next state and request valid
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    next_tag_d = next_tag_q;
    num_req_d  = num_req_q;
    // Gated on watchdog expiry so no request slips into a slot being cleared.
    so_w       = (state_q == ST_ISSUE) && !pending[next_tag_q[SLOT_W-1:0]] && !wd_expire;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_req_d  = num_req;
          next_tag_d = '0;
          state_d    = (num_req == 8'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_fire) begin
          next_tag_d = next_tag_q + 8'd1;
          if (next_tag_d == num_req_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_w == 5'd0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_expire) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      next_tag_q <= '0;
      num_req_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_tag_q <= next_tag_d;
      num_req_q  <= num_req_d;
      err_q      <= err_q || (reply_fire && reply_bad);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional reply watchdog
  // ---------------------------------------------------------------------------
`ifdef CD_INIT_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        wd_run;
  logic        timeout_q;

  // Counts only while waiting on replies; any reply flit or idle period reloads it.
  assign wd_run    = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                     (outstanding_w != 5'd0) && !reply_fire;
  assign wd_expire = wd_run && (wd_q == WD_LIMIT - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= (wd_run && !wd_expire) ? wd_q + 16'd1 : 16'd0;
      timeout_q <= timeout_q || wd_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Slot tracking
  // ---------------------------------------------------------------------------
  cd_init_slot_tracker #(
    .MAX_OUT (MAX_OUT),
    .BURST   (BURST),
    .SLOT_W  (SLOT_W)
  ) u_slots (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (wd_expire),
    .issue_i       (req_fire),
    .issue_slot_i  (next_tag_q[SLOT_W-1:0]),
    .reply_i       (reply_ok),
    .reply_slot_i  (reply_slot),
    .pending_o     (pending),
    .outstanding_o (outstanding_w)
  );

  assign so          = so_w;
  assign do_o        = so_w ? req_flit : '0;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign outstanding = outstanding_w;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cd_req_initiator.sv
// -----------------------------------------------------------------------------
// tb_cd_req_initiator -- directed bench for cd_req_initiator (default params).
// Expected request flits are queued when a run is started and compared as the
// DUT transfers them; a responder process replays reply flits from a queue.
// -----------------------------------------------------------------------------
module tb_cd_req_initiator;

  localparam int DATA_W = 64;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset   = 1'b0;
  logic              start   = 1'b0;
  logic [7:0]        num_req = 8'd0;
  logic              ro      = 1'b1;
  logic              si_r    = 1'b0;
  logic [DATA_W-1:0] di_r    = '0;
  logic              so, ri_r, busy, done, err, timeout;
  logic [DATA_W-1:0] do_o;
  logic [4:0]        outstanding;
  logic [1:0]        dbg_state;

  cd_req_initiator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_req     (num_req),
    .so          (so),
    .ro          (ro),
    .do_o        (do_o),
    .si_r        (si_r),
    .ri_r        (ri_r),
    .di_r        (di_r),
    .busy        (busy),
    .done        (done),
    .outstanding (outstanding),
    .err         (err),
    .timeout     (timeout),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [63:0] exp_q[$];
  logic [63:0] rsp_flit_q[$];
  int          rsp_due_q[$];
  bit          rsp_auto = 1'b0;
  int          n_xfer = 0;
  int          last_xfer_cyc = 0;
  int          done_cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] mon_exp;
  logic [63:0] saved_do;
  int          base;

  function automatic logic [63:0] exp_flit(input int t);
    logic [7:0] tg;
    tg = t[7:0];
    return {tg[1:0], 4'h0, tg, 42'b0, tg};
  endfunction

  function automatic logic [63:0] rep_flit(input logic [3:0] src, input logic [7:0] tag);
    return {2'b00, src, tag, 50'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_run(input int n);
    for (int t = 0; t < n; t++) exp_q.push_back(exp_flit(t));
  endtask

  task automatic push_reply(input logic [3:0] src, input logic [7:0] tag);
    rsp_flit_q.push_back(rep_flit(src, tag));
    rsp_due_q.push_back(cyc);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start   = 1'b1;
    num_req = n;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    done_cyc = cyc;
    check("run_done", done, 1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    tick(n);
    reset = 1'b1;
    tick(1);
  endtask

  // Request monitor: scoreboards every transfer, optionally schedules replies.
  always begin
    @(negedge clk);
    #3;
    if (reset && so && ro) begin
      n_xfer++;
      last_xfer_cyc = cyc;
      check("req_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("req_flit", do_o, mon_exp);
        if (rsp_auto) begin
          repeat (2) begin
            rsp_flit_q.push_back(rep_flit(4'h0, mon_exp[57:50]));
            rsp_due_q.push_back(cyc + 2);
          end
        end
      end
    end
  end

  // Responder: one reply flit per cycle once due.
  always begin
    @(posedge clk);
    #1;
    if (rsp_flit_q.size() != 0 && rsp_due_q[0] <= cyc) begin
      si_r = 1'b1;
      di_r = rsp_flit_q.pop_front();
      void'(rsp_due_q.pop_front());
    end else begin
      si_r = 1'b0;
      di_r = '0;
    end
  end

  initial begin
    // ---- reset state ----
    tick(3);
    check("rst_so", so, 0);
    check("rst_do", do_o, 0);
    check("rst_ri_r", ri_r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    tick(1);
    check("ri_r_after_reset", ri_r, 1);

    // ---- run of 8, responder replies 2 flits after 2 cycles ----
    rsp_auto = 1'b1;
    base = n_xfer;
    push_run(8);
    pulse_start(8'd8);
    check("a_so_after_start", so, 1);
    check("a_busy", busy, 1);
    wait_done(300);
    check("a_xfers", 64'(n_xfer - base), 8);
    check("a_exp_empty", 64'(exp_q.size()), 0);
    check("a_err", err, 0);
    check("a_outstanding", outstanding, 0);
    check("a_busy_end", busy, 0);

    // ---- ro held low: do stable, single transfer ----
    ro = 1'b0;
    base = n_xfer;
    push_run(1);
    pulse_start(8'd1);
    saved_do = do_o;
    check("b_do_first", saved_do, exp_flit(0));
    for (int i = 0; i < 5; i++) begin
      check("b_so_held", so, 1);
      check("b_do_stable", do_o, saved_do);
      tick(1);
    end
    check("b_no_xfer_stalled", 64'(n_xfer - base), 0);
    ro = 1'b1;
    wait_done(100);
    check("b_xfers", 64'(n_xfer - base), 1);
    check("b_err", err, 0);

    // ---- replies withheld, 6 requests, 4 slots ----
    rsp_auto = 1'b0;
    base = n_xfer;
    push_run(6);
    pulse_start(8'd6);
    tick(20);
    check("c_xfers_capped", 64'(n_xfer - base), 4);
    check("c_outstanding_full", outstanding, 4);
    check("c_so_stalled", so, 0);
    push_reply(4'h0, 8'd0);
    tick(3);
    check("c_so_half_burst", so, 0);
    check("c_xfers_half_burst", 64'(n_xfer - base), 4);
    push_reply(4'h0, 8'd0);
    tick(4);
    check("c_xfers_after_retire", 64'(n_xfer - base), 5);
    check("c_outstanding_refill", outstanding, 4);
    for (int t = 1; t < 6; t++) begin
      push_reply(4'h0, 8'(t));
      push_reply(4'h0, 8'(t));
    end
    wait_done(100);
    check("c_xfers", 64'(n_xfer - base), 6);
    check("c_outstanding_end", outstanding, 0);
    check("c_err", err, 0);

    // ---- start from DONE, interleaved replies, start ignored in DRAIN ----
    base = n_xfer;
    push_run(2);
    pulse_start(8'd2);
    tick(5);
    check("d_outstanding", outstanding, 2);
    check("d_state_drain", dbg_state, 2);
    pulse_start(8'd5);
    check("d_start_ignored", dbg_state, 2);
    push_reply(4'h0, 8'd1);
    push_reply(4'h0, 8'd0);
    push_reply(4'h0, 8'd1);
    push_reply(4'h0, 8'd0);
    wait_done(50);
    check("d_outstanding_end", outstanding, 0);
    check("d_xfers", 64'(n_xfer - base), 2);
    check("d_err", err, 0);

    // ---- stray reply while idle, zero-length run ----
    do_reset(2);
    check("e_idle_state", dbg_state, 0);
    push_reply(4'h0, 8'd9);
    tick(3);
    check("e_err_tag9", err, 1);
    check("e_outstanding", outstanding, 0);
    check("e_busy", busy, 0);
    pulse_start(8'd0);
    check("e_done_next_cycle", done, 1);
    check("e_so_zero_run", so, 0);

    // ---- bad source id, then reset mid-run ----
    do_reset(2);
    check("f_err_cleared", err, 0);
    base = n_xfer;
    push_run(4);
    pulse_start(8'd4);
    tick(8);
    check("f_outstanding", outstanding, 4);
    check("f_xfers", 64'(n_xfer - base), 4);
    push_reply(4'h3, 8'd0);
    tick(3);
    check("f_err_src", err, 1);
    check("f_outstanding_kept", outstanding, 4);
    reset = 1'b0;
    tick(1);
    check("f_rst_outstanding", outstanding, 0);
    check("f_rst_state", dbg_state, 0);
    check("f_rst_err", err, 0);
    reset = 1'b1;
    tick(1);
    push_reply(4'h0, 8'd0);
    tick(3);
    check("f_err_abandoned", err, 1);
    check("f_outstanding_zero", outstanding, 0);

`ifdef CD_INIT_TIMEOUT_EN
    // ---- watchdog expiry with replies withheld ----
    do_reset(2);
    push_run(2);
    pulse_start(8'd2);
    wait_done(1300);
    check("g_timeout", timeout, 1);
    check("g_outstanding", outstanding, 0);
    check("g_timeout_latency_ok",
          64'((done_cyc - last_xfer_cyc >= 995) && (done_cyc - last_xfer_cyc <= 1005)), 1);
`else
    check("g_timeout_tied", timeout, 0);
`endif

    check("exp_queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
